// File: rtl/lsu_store_queue.sv
// rtl/lsu_store_queue.sv - in-order store queue with prioritised, hazard-checked loads
module lsu_store_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        req_err,
   output logic        load_valid,
   output logic [63:0] load_data,
   output logic        sq_empty,
   output logic        mem_write_en,
   output logic        mem_read_en,
   output logic [1:0]  store_format,
   output logic [2:0]  load_format,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_data_input,
   input  logic [63:0] mem_data_output
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   state_t        state;
   logic [63:0]   q_addr [DEPTH];
   logic [63:0]   q_data [DEPTH];
   logic [1:0]    q_fmt  [DEPTH];
   logic [DEPTH-1:0] q_vld;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [63:0]   ld_addr;
   logic [2:0]    ld_funct3;

   logic          full;
   logic          hazard;
   logic          illegal;
   logic          accept;
   logic          enq;
   logic          ld_acc;
   logic          pop;
   logic [63:0]   ext_data;

   assign full    = (count == CW'(DEPTH));
   assign illegal = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
   assign req_ready = req_is_store ? !full : ((state == ST_IDLE) && !full && !hazard);
   assign accept  = req_valid && req_ready;
   assign enq     = accept && req_is_store && !illegal;
   assign ld_acc  = accept && !req_is_store && !illegal;
   assign pop     = (state == ST_WRITE);
   assign sq_empty = (count == '0) && (state != ST_WRITE);

   // A load may not pass any queued store that touches the same doubleword
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (q_vld[i] && (q_addr[i][63:3] == req_addr[63:3])) begin
            hazard = 1'b1;
         end
      end
   end

   // Sign- or zero-extend the raw memory word according to the latched funct3
   always_comb begin
      ext_data = mem_data_output;
      case (ld_funct3)
         3'b000:  ext_data = {{56{mem_data_output[7]}},  mem_data_output[7:0]};
         3'b100:  ext_data = {56'd0,                     mem_data_output[7:0]};
         3'b001:  ext_data = {{48{mem_data_output[15]}}, mem_data_output[15:0]};
         3'b101:  ext_data = {48'd0,                     mem_data_output[15:0]};
         3'b010:  ext_data = {{32{mem_data_output[31]}}, mem_data_output[31:0]};
         3'b110:  ext_data = {32'd0,                     mem_data_output[31:0]};
         default: ext_data = mem_data_output;
      endcase
   end

   // Memory-side outputs depend only on the state and registered fields
   always_comb begin
      mem_write_en   = (state == ST_WRITE);
      mem_read_en    = (state == ST_READ);
      mem_addr       = 64'd0;
      mem_data_input = 64'd0;
      store_format   = 2'b00;
      load_format    = 3'b000;
      if (state == ST_WRITE) begin
         mem_addr       = q_addr[rd_ptr];
         mem_data_input = q_data[rd_ptr];
         store_format   = q_fmt[rd_ptr];
      end else if (state == ST_READ) begin
         mem_addr    = ld_addr;
         load_format = (ld_funct3[1:0] == 2'b11) ? 3'b101 : {1'b0, ld_funct3[1:0]};
      end
   end

   // Queue payload storage; validity is tracked separately so no reset is needed here
   always_ff @(posedge clk) begin
      if (enq) begin
         q_addr[wr_ptr] <= req_addr;
         q_data[wr_ptr] <= req_wdata;
         q_fmt[wr_ptr]  <= req_funct3[1:0];
      end
   end

   // Queue bookkeeping, access FSM and load-return registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         q_vld      <= '0;
         ld_addr    <= 64'd0;
         ld_funct3  <= 3'b000;
         load_valid <= 1'b0;
         load_data  <= 64'd0;
         req_err    <= 1'b0;
      end else begin
         req_err    <= accept && illegal;
         load_valid <= (state == ST_READ);

         if (pop) begin
            q_vld[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PW'(1);
         end
         if (enq) begin
            q_vld[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         case ({enq, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         case (state)
            ST_IDLE: begin
               if (full) begin
                  state <= ST_WRITE;
               end else if (ld_acc) begin
                  ld_addr   <= req_addr;
                  ld_funct3 <= req_funct3;
                  state     <= ST_READ;
               end else if (count != '0) begin
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: state <= ST_IDLE;
            ST_READ: begin
               load_data <= ext_data;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_store_queue.sv
// tb/tb_lsu_store_queue.sv - scoreboard bench with a byte-array reference memory
module tb_lsu_store_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        req_err;
   logic        load_valid;
   logic [63:0] load_data;
   logic        sq_empty;
   logic        mem_write_en;
   logic        mem_read_en;
   logic [1:0]  store_format;
   logic [2:0]  load_format;
   logic [63:0] mem_addr;
   logic [63:0] mem_data_input;
   logic [63:0] mem_data_output = 64'd0;

   lsu_store_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_err(req_err), .load_valid(load_valid), .load_data(load_data),
      .sq_empty(sq_empty), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
      .store_format(store_format), .load_format(load_format), .mem_addr(mem_addr),
      .mem_data_input(mem_data_input), .mem_data_output(mem_data_output)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct { logic [63:0] addr; logic [63:0] data; logic [1:0] fmt; } st_t;
   typedef struct { logic [63:0] val; logic [63:0] addr; logic [2:0] fmt; int cyc; } ld_t;
   st_t pend[$];
   ld_t ldq[$];
   int  errq[$];
   bit  pop_next = 1'b0;
   bit  prev_acc = 1'b0;

   logic [7:0] dmem [0:1023];
   logic [7:0] rmem [0:1023];
   int writes_done = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] ref_lfmt(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 3'b000;
         3'b001, 3'b101: return 3'b001;
         3'b010, 3'b110: return 3'b010;
         default:        return 3'b101;
      endcase
   endfunction

   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr);
      int n;
      int sh;
      logic [63:0] v;
      n = 1 << f3[1:0];
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[addr[9:0] + 10'(i)];
      if (!f3[2] && n < 8) begin
         sh = 64 - 8 * n;
         v = $signed(v << sh) >>> sh;
      end
      return v;
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data);
      for (int i = 0; i < (1 << f3[1:0]); i++) rmem[addr[9:0] + 10'(i)] = data[8*i +: 8];
   endtask

   // data_memory stand-in: byte array, written and read mid-cycle
   always @(negedge clk) begin : mem_model
      logic [63:0] v;
      int n;
      if (mem_write_en) begin
         for (int i = 0; i < (1 << store_format); i++)
            dmem[mem_addr[9:0] + 10'(i)] = mem_data_input[8*i +: 8];
         writes_done++;
      end
      if (mem_read_en) begin
         case (load_format)
            3'b000:  n = 1;
            3'b001:  n = 2;
            3'b010:  n = 4;
            3'b101:  n = 8;
            default: n = 0;
         endcase
         v = 64'd0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = dmem[mem_addr[9:0] + 10'(i)];
         mem_data_output = v;
      end
   end

   // Monitor: pops scoreboard entries whenever the DUT presents an output
   always @(posedge clk) begin
      ld_t e;
      #2;
      if (rst_n) begin
         if (pop_next) begin
            if (pend.size() > 0) void'(pend.pop_front());
            pop_next = 1'b0;
         end
         if (mem_write_en || mem_read_en) begin
            chk("enable_exclusive", {63'd0, mem_write_en & mem_read_en}, 64'd0);
            chk("idle_between_access", {63'd0, prev_acc}, 64'd0);
         end
         if (mem_write_en) begin
            if (pend.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
            else begin
               chk("write_addr", mem_addr, pend[0].addr);
               chk("write_data", mem_data_input, pend[0].data);
               chk("store_format", {62'd0, store_format}, {62'd0, pend[0].fmt});
               pop_next = 1'b1;
            end
         end
         if (mem_read_en) begin
            if (ldq.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
            else begin
               chk("read_addr", mem_addr, ldq[0].addr);
               chk("load_format", {61'd0, load_format}, {61'd0, ldq[0].fmt});
            end
         end
         if (load_valid) begin
            if (ldq.size() == 0) chk("unexpected_load_valid", 64'd1, 64'd0);
            else begin
               e = ldq.pop_front();
               chk("load_data", load_data, e.val);
               chk("load_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
         end else if (ldq.size() > 0 && cyc > ldq[0].cyc) begin
            chk("load_valid_missing", 64'd0, 64'd1);
            void'(ldq.pop_front());
         end
         if (req_err) begin
            if (errq.size() == 0) chk("unexpected_req_err", 64'd1, 64'd0);
            else chk("req_err_cycle", 64'(cyc), 64'(errq.pop_front()));
         end else if (errq.size() > 0 && cyc > errq[0]) begin
            chk("req_err_missing", 64'd0, 64'd1);
            void'(errq.pop_front());
         end
         chk("sq_empty", {63'd0, sq_empty}, {63'd0, pend.size() == 0});
         prev_acc = mem_write_en || mem_read_en;
      end
   end

   // Issue one request for one cycle; push expectations if the DUT takes it
   task automatic req(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] data, output bit acc);
      bit full;
      bit hz;
      bit exp_rdy;
      bit ill;
      st_t s;
      ld_t l;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_is_store = st;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = data;
      @(negedge clk);
      #1;
      full = pend.size() >= DEPTH;
      hz = 1'b0;
      foreach (pend[i]) if (pend[i].addr[63:3] == addr[63:3]) hz = 1'b1;
      exp_rdy = st ? !full : (!full && !hz && !mem_write_en && !mem_read_en);
      chk(st ? "req_ready_store" : "req_ready_load", {63'd0, req_ready}, {63'd0, exp_rdy});
      acc = req_ready;
      if (acc) begin
         ill = st ? f3[2] : (f3 == 3'b111);
         if (ill) errq.push_back(cyc + 1);
         else if (st) begin
            s.addr = addr; s.data = data; s.fmt = f3[1:0];
            pend.push_back(s);
            ref_store(f3, addr, data);
         end else begin
            l.val = ref_load(f3, addr); l.addr = addr; l.fmt = ref_lfmt(f3); l.cyc = cyc + 2;
            ldq.push_back(l);
         end
      end
   endtask

   task automatic req_hold(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] data, output int stalls);
      bit acc;
      acc = 1'b0;
      stalls = 0;
      for (int k = 0; k < 64 && !acc; k++) begin
         req(st, f3, addr, data, acc);
         if (!acc) stalls++;
      end
      if (!acc) chk("req_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_cycle();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         wait_cycle();
         done = sq_empty && ldq.size() == 0 && errq.size() == 0 && pend.size() == 0;
      end
      if (!done) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int stalls;
      bit acc;
      bit st;
      logic [2:0] f3;
      logic [63:0] a;
      logic [63:0] d;
      int sz;
      logic [7:0] s;
      int first;
      int diffs;
      int w0;

      for (int i = 0; i < 1024; i++) begin
         dmem[i] = 8'h00;
         rmem[i] = 8'h00;
      end

      // reset with a request pending
      req_valid = 1'b1;
      req_is_store = 1'b0;
      req_funct3 = 3'b011;
      req_addr = 64'h100;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_write_en", {63'd0, mem_write_en}, 64'd0);
      chk("rst_read_en", {63'd0, mem_read_en}, 64'd0);
      chk("rst_load_valid", {63'd0, load_valid}, 64'd0);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_sq_empty", {63'd0, sq_empty}, 64'd1);
      chk("rst_req_err", {63'd0, req_err}, 64'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // doubleword store followed by loads of several widths
      req_hold(1'b1, 3'b011, 64'h100, 64'h1122334455667788, stalls);
      wait_drain();
      req_hold(1'b0, 3'b011, 64'h100, 64'd0, stalls);
      req_hold(1'b0, 3'b000, 64'h100, 64'd0, stalls);
      req_hold(1'b0, 3'b100, 64'h100, 64'd0, stalls);
      req_hold(1'b0, 3'b101, 64'h106, 64'd0, stalls);
      req_hold(1'b0, 3'b010, 64'h104, 64'd0, stalls);
      wait_drain();

      // stream of byte stores fills the queue; order must survive
      first = 0;
      for (int k = 0; k < 8; k++) begin
         req_hold(1'b1, 3'b000, 64'h180 + 64'(k % 3), 64'hA0 + 64'(k), stalls);
         first += stalls;
      end
      chk("queue_full_stall_seen", {63'd0, first > 0}, 64'd1);
      wait_drain();
      req_hold(1'b0, 3'b011, 64'h180, 64'd0, stalls);
      wait_drain();

      // load to a doubleword with a pending store stalls; other doubleword does not
      req_hold(1'b1, 3'b010, 64'h208, 64'hDEADBEEF, stalls);
      req_hold(1'b0, 3'b010, 64'h20C, 64'd0, stalls);
      chk("hazard_stall_seen", {63'd0, stalls > 0}, 64'd1);
      wait_drain();
      req_hold(1'b1, 3'b010, 64'h208, 64'h12345678, stalls);
      req(1'b0, 3'b110, 64'h210, 64'd0, acc);
      chk("no_hazard_other_dword", {63'd0, acc}, 64'd1);
      wait_drain();
      req_hold(1'b0, 3'b010, 64'h208, 64'd0, stalls);
      wait_drain();

      // identical byte stores: write enable must drop between them
      req_hold(1'b1, 3'b000, 64'h300, 64'h5A, stalls);
      req_hold(1'b1, 3'b000, 64'h301, 64'h5A, stalls);
      s = 8'h00;
      for (int k = 0; k < 8; k++) begin
         wait_cycle();
         s[k] = mem_write_en;
      end
      first = -1;
      for (int k = 7; k >= 0; k--) if (s[k]) first = k;
      if (first < 0 || first > 5) chk("write_en_seq_found", 64'd0, 64'd1);
      else chk("write_en_seq", {61'd0, s[first], s[first+1], s[first+2]}, 64'b101);
      req_hold(1'b0, 3'b100, 64'h300, 64'd0, stalls);
      req_hold(1'b0, 3'b100, 64'h301, 64'd0, stalls);
      wait_drain();

      // illegal funct3 requests are dropped with an error pulse
      req_hold(1'b0, 3'b111, 64'h300, 64'd0, stalls);
      for (int k = 0; k < 3; k++) begin
         wait_cycle();
         chk("illegal_load_no_read", {63'd0, mem_read_en}, 64'd0);
      end
      req_hold(1'b1, 3'b100, 64'h300, 64'hFF, stalls);
      wait_drain();
      req_hold(1'b0, 3'b000, 64'h300, 64'd0, stalls);
      wait_drain();

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            st = 1'($urandom_range(0, 1));
            if (st) begin
               f3 = 3'($urandom_range(0, 3));
               if ($urandom_range(0, 19) == 0) f3[2] = 1'b1;
            end else begin
               f3 = 3'($urandom_range(0, 6));
               if ($urandom_range(0, 19) == 0) f3 = 3'b111;
            end
            sz = 1 << f3[1:0];
            a = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7) & ~(sz - 1));
            d = {$urandom, $urandom};
            req(st, f3, a, d, acc);
         end else begin
            wait_cycle();
         end
      end
      wait_drain();
      repeat (3) wait_cycle();
      chk("loads_outstanding", 64'(ldq.size()), 64'd0);
      diffs = 0;
      for (int i = 0; i < 1024; i++) if (dmem[i] !== rmem[i]) diffs++;
      chk("memory_image_diffs", 64'(diffs), 64'd0);

      // reset in the middle of a WRITE discards the queue
      req_hold(1'b1, 3'b011, 64'h3C0, 64'h0102030405060708, stalls);
      req_hold(1'b1, 3'b011, 64'h3C8, 64'h1112131415161718, stalls);
      req_hold(1'b1, 3'b011, 64'h3D0, 64'h2122232425262728, stalls);
      acc = 1'b0;
      for (int k = 0; k < 10 && !acc; k++) begin
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         #2;
         acc = mem_write_en;
      end
      chk("found_write_cycle", {63'd0, acc}, 64'd1);
      rst_n = 1'b0;
      pend.delete();
      ldq.delete();
      errq.delete();
      pop_next = 1'b0;
      prev_acc = 1'b0;
      #1;
      w0 = writes_done;
      chk("midrst_write_en", {63'd0, mem_write_en}, 64'd0);
      chk("midrst_read_en", {63'd0, mem_read_en}, 64'd0);
      chk("midrst_sq_empty", {63'd0, sq_empty}, 64'd1);
      chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("midrst_mem_addr", mem_addr, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) wait_cycle();
      chk("no_writes_after_reset", 64'(writes_done), 64'(w0));
      chk("sq_empty_after_reset", {63'd0, sq_empty}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
